// File: rtl/command_issuer.sv
// command_issuer: buffers 12-bit ALU commands in a FIFO and issues them one at
// a time to the controller. Each issue is a one-cycle syscall pulse. Pulses are
// spaced ISSUE_GAP cycles apart so the controller is back in IDLE before the
// next one arrives.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   cmd_valid/data  producer command; accepted when cmd_ready (= !full)
//   hold            blocks new issues while the FSM is idle
//   command         command presented to the controller
//   syscall         one-cycle run pulse
//   busy            FSM not idle
//   fifo_count      entries held, 0..DEPTH
//   issued_count    commands issued since reset (wraps)
module command_issuer #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned ISSUE_GAP = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    input  logic [11:0]              cmd_data,
    output logic                     cmd_ready,
    input  logic                     hold,
    output logic [11:0]              command,
    output logic                     syscall,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [15:0]              issued_count
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CW   = AW + 1;
    localparam int unsigned CNTW = $clog2(ISSUE_GAP) + 1;
    localparam int unsigned CMDW = 12;
    localparam int unsigned ICW  = 16;

    // Reject illegal parameterisations at elaboration.
    if (ISSUE_GAP < 5) begin : g_gap_chk
        $fatal(1, "command_issuer: ISSUE_GAP must be >= 5");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_chk
        $fatal(1, "command_issuer: DEPTH must be a power of 2 and >= 2");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CMDW-1:0]     mem_q [DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic [CNTW-1:0]     cnt_q, cnt_d;
    logic [CMDW-1:0]     command_q, command_d;
    logic                syscall_q, syscall_d;
    logic                busy_q, busy_d;
    logic [ICW-1:0]      issued_q, issued_d;
    logic                full, empty, push, pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    // A push is refused while full, even on the edge that pops.
    assign push  = cmd_valid && !full;

    // Next-state, FIFO bookkeeping and output computation.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        command_d = command_q;
        issued_d  = issued_q;
        pop       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!empty && !hold) begin
                    command_d = mem_q[rd_ptr_q];
                    pop       = 1'b1;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // ISSUE, the pulse cycle and the WAIT countdown add up to ISSUE_GAP.
                cnt_d    = CNTW'(ISSUE_GAP - 3);
                issued_d = issued_q + ICW'(1);
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNTW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        syscall_d = (state_q == S_ISSUE);
        busy_d    = (state_d != S_IDLE);
        wr_ptr_d  = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d   = count_q + CW'(push) - CW'(pop);
    end

    // State and control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            cnt_q     <= '0;
            command_q <= '0;
            syscall_q <= 1'b0;
            busy_q    <= 1'b0;
            issued_q  <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            cnt_q     <= cnt_d;
            command_q <= command_d;
            syscall_q <= syscall_d;
            busy_q    <= busy_d;
            issued_q  <= issued_d;
        end
    end

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= cmd_data;
        end
    end

    assign cmd_ready    = !full;
    assign command      = command_q;
    assign syscall      = syscall_q;
    assign busy         = busy_q;
    assign fifo_count   = count_q;
    assign issued_count = issued_q;

endmodule

// File: tb/tb_command_issuer.sv
// Self-checking bench for command_issuer: a queue-based reference model that
// treats issuing as "pop at most once every ISSUE_GAP edges, pulse on the edge
// after the pop", compared against the DUT every cycle, plus literal checks.
module tb_command_issuer;

    localparam int unsigned DEPTH     = 8;
    localparam int unsigned ISSUE_GAP = 5;
    localparam int unsigned CW        = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst;
    logic          cmd_valid;
    logic [11:0]   cmd_data;
    logic          cmd_ready;
    logic          hold;
    logic [11:0]   command;
    logic          syscall;
    logic          busy;
    logic [CW-1:0] fifo_count;
    logic [15:0]   issued_count;

    command_issuer #(.DEPTH(DEPTH), .ISSUE_GAP(ISSUE_GAP)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_data     (cmd_data),
        .cmd_ready    (cmd_ready),
        .hold         (hold),
        .command      (command),
        .syscall      (syscall),
        .busy         (busy),
        .fifo_count   (fifo_count),
        .issued_count (issued_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [11:0] q[$];
    int          edge_no  = 0;
    int          last_pop = -1000;
    logic [11:0] m_cmd    = '0;
    logic [15:0] m_issued = '0;
    logic        m_sys    = 1'b0;
    logic        m_busy   = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", nm, edge_no, act, exp);
        end
    endtask

    task automatic model_edge(input logic v, input logic [11:0] d, input logic h, input logic r);
        logic do_pop, do_push;
        if (r) begin
            q.delete();
            m_cmd    = '0;
            m_issued = '0;
            last_pop = -1000;
            m_sys    = 1'b0;
            m_busy   = 1'b0;
        end else begin
            do_pop  = ((edge_no - last_pop) >= int'(ISSUE_GAP)) && (q.size() > 0) && !h;
            do_push = v && (q.size() < int'(DEPTH));
            m_sys   = ((edge_no - last_pop) == 1);
            if (m_sys) m_issued = m_issued + 16'd1;
            if (do_pop) begin
                m_cmd    = q.pop_front();
                last_pop = edge_no;
            end
            if (do_push) q.push_back(d);
            m_busy = ((edge_no - last_pop) <= int'(ISSUE_GAP) - 2);
        end
        edge_no++;
    endtask

    task automatic compare();
        chk("syscall",      32'(syscall),      32'(m_sys));
        chk("busy",         32'(busy),         32'(m_busy));
        chk("command",      32'(command),      32'(m_cmd));
        chk("issued_count", 32'(issued_count), 32'(m_issued));
        chk("fifo_count",   32'(fifo_count),   32'(q.size()));
        chk("cmd_ready",    32'(cmd_ready),    32'(q.size() < int'(DEPTH)));
    endtask

    // One clock: drive inputs, advance model at the edge, compare at negedge.
    task automatic step(input logic v, input logic [11:0] d, input logic h, input logic r);
        cmd_valid = v;
        cmd_data  = d;
        hold      = h;
        rst       = r;
        @(posedge clk);
        model_edge(v, d, h, r);
        @(negedge clk);
        compare();
    endtask

    int pulses[$];
    logic [11:0] pcmds[$];
    logic [11:0] lit;

    initial begin
        cmd_valid = 1'b0;
        cmd_data  = '0;
        hold      = 1'b0;
        rst       = 1'b1;

        // Reset state.
        step(0, 12'h000, 0, 1);
        step(0, 12'h000, 0, 1);
        chk("reset_ready", 32'(cmd_ready), 32'd1);
        chk("reset_count", 32'(fifo_count), 32'd0);
        chk("reset_busy",  32'(busy), 32'd0);

        // Single command: push at edge 0, pulse after edge 2.
        step(1, 12'h0C5, 0, 0);
        step(0, 12'h000, 0, 0);
        chk("t1_no_early_pulse", 32'(syscall), 32'd0);
        step(0, 12'h000, 0, 0);
        chk("t1_pulse",   32'(syscall), 32'd1);
        chk("t1_command", 32'(command), 32'h0C5);
        for (int i = 3; i <= 6; i++) step(0, 12'h000, 0, 0);
        chk("t1_issued", 32'(issued_count), 32'd1);
        chk("t1_fifo",   32'(fifo_count), 32'd0);
        chk("t1_busy",   32'(busy), 32'd0);

        // Three back-to-back pushes: pulses 5 apart, in push order.
        for (int k = 0; k < 16; k++) begin
            case (k)
                0: lit = 12'h001;
                1: lit = 12'h202;
                2: lit = 12'hE53;
                default: lit = 12'h000;
            endcase
            step(k < 3, lit, 0, 0);
            if (syscall) begin
                pulses.push_back(k);
                pcmds.push_back(command);
            end
        end
        chk("t2_npulses", 32'(pulses.size()), 32'd3);
        if (pulses.size() == 3) begin
            chk("t2_p0", 32'(pulses[0]), 32'd2);
            chk("t2_p1", 32'(pulses[1]), 32'd7);
            chk("t2_p2", 32'(pulses[2]), 32'd12);
            chk("t2_c0", 32'(pcmds[0]), 32'h001);
            chk("t2_c1", 32'(pcmds[1]), 32'h202);
            chk("t2_c2", 32'(pcmds[2]), 32'hE53);
        end

        // Nine pushes under hold: only eight accepted.
        for (int k = 0; k < 9; k++) step(1, 12'(12'h100 + k), 1, 0);
        chk("t3_ready_low", 32'(cmd_ready), 32'd0);
        chk("t3_fifo_full", 32'(fifo_count), 32'd8);
        for (int k = 0; k < 45; k++) step(0, 12'h000, 0, 0);
        chk("t3_drained", 32'(fifo_count), 32'd0);
        chk("t3_issued",  32'(issued_count), 32'd12);

        // Full FIFO with cmd_valid held: refused on the pop edge, accepted next.
        for (int k = 0; k < 8; k++) step(1, 12'(12'h300 + k), 1, 0);
        step(1, 12'h3AA, 0, 0);
        chk("t4_pop_edge", 32'(fifo_count), 32'd7);
        step(1, 12'h3AB, 0, 0);
        chk("t4_after_push", 32'(fifo_count), 32'd8);
        for (int k = 0; k < 50; k++) step(0, 12'h000, 0, 0);

        // Reset while waiting with three queued.
        for (int k = 0; k < 4; k++) step(1, 12'(12'h500 + k), 1, 0);
        step(0, 12'h000, 0, 0);
        step(0, 12'h000, 0, 0);
        step(0, 12'h000, 0, 0);
        chk("t5_pre_fifo", 32'(fifo_count), 32'd3);
        step(0, 12'h000, 0, 1);
        chk("t5_syscall", 32'(syscall), 32'd0);
        chk("t5_busy",    32'(busy), 32'd0);
        chk("t5_fifo",    32'(fifo_count), 32'd0);
        chk("t5_issued",  32'(issued_count), 32'd0);
        for (int k = 0; k < 20; k++) step(0, 12'h000, 0, 0);

        // Issued counter wrap.
        force dut.issued_q = 16'hFFFF;
        m_issued = 16'hFFFF;
        step(0, 12'h000, 0, 0);
        release dut.issued_q;
        step(1, 12'hE77, 0, 0);
        for (int k = 0; k < 6; k++) step(0, 12'h000, 0, 0);
        chk("t6_wrap", 32'(issued_count), 32'd0);

        // Randomised traffic, occasional reset.
        for (int k = 0; k < 3000; k++) begin
            step($urandom_range(0, 99) < 60, 12'($urandom), $urandom_range(0, 9) < 2,
                 $urandom_range(0, 399) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
